// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide sequencer that owns the MIPS HI/LO registers.
// A multiply uses LSB-first shift-add and a divide is restoring; each takes 32 iterations plus one FIX cycle.
module muldiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic        HIwrite,
  input  logic        LOwrite,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        is_div_q, is_div_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] raw_a_q, raw_a_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Operand magnitudes and signs; unsigned ops (op[0] = 1) keep the raw values.
  logic        in_signed, a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  assign in_signed = ~op[0];
  assign a_neg     = in_signed & ReadData1[31];
  assign b_neg     = in_signed & ReadData2[31];
  assign mag_a     = a_neg ? (~ReadData1 + 32'd1) : ReadData1;
  assign mag_b     = b_neg ? (~ReadData2 + 32'd1) : ReadData2;

  // acc holds {partial product, remaining multiplier} while multiplying.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // acc holds {remainder, quotient} while dividing; bit 32 of the shifted remainder is kept.
  logic [32:0] div_sh, div_sub;
  logic        div_ge;
  logic [63:0] div_next;
  assign div_sh   = acc_q[63:31];
  assign div_sub  = div_sh - {1'b0, b_q};
  assign div_ge   = div_sh >= {1'b0, b_q};
  assign div_next = {(div_ge ? div_sub[31:0] : div_sh[31:0]), acc_q[30:0], div_ge};

  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;
  assign prod_fix = neg_q ? (~acc_q + 64'd1) : acc_q;
  assign quot_fix = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix  = rem_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    a_d       = a_q;
    b_d       = b_q;
    raw_a_d   = raw_a_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d  = op[1];
          a_d       = mag_a;
          b_d       = mag_b;
          raw_a_d   = ReadData1;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          acc_d     = op[1] ? {32'd0, mag_a} : {32'd0, mag_b};
          cnt_d     = 6'd0;
          busy_d    = 1'b1;
          state_d   = CALC;
        end else begin
          if (HIwrite) hi_d = ReadData1;
          if (LOwrite) lo_d = ReadData1;
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (b_q == 32'd0) begin
          hi_d = raw_a_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      raw_a_q   <= 32'd0;
      acc_q     <= 64'd0;
      cnt_q     <= 6'd0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      a_q       <= a_d;
      b_q       <= b_d;
      raw_a_q   <= raw_a_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign HI        = hi_q;
  assign LO        = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide sequencer for the MIPS `mult`, `multu`, `div` and `divu` instructions, owning the architectural HI/LO registers. It sits beside the ALU in the execute stage. It accepts a one-cycle start pulse with the `rs`/`rt` operands, runs a 32-iteration shift-add or restoring-divide datapath, and raises `busy` so the controller stalls `mfhi`/`mflo` and further mul/div instructions until `done`. `mthi`/`mtlo` also write HI/LO through this block.

## Interface
- none (operand width fixed at 32)

- `clock` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-high
- `start` in 1: launch operation; sampled only in IDLE
- `op` in 2: 00 mult, 01 multu, 10 div, 11 divu; sampled with `start`
- `ReadData1` in 32: `rs` (multiplicand/dividend); also mthi/mtlo data
- `ReadData2` in 32: `rt` (multiplier/divisor)
- `HIwrite` in 1: mthi, HI <= ReadData1
- `LOwrite` in 1: mtlo, LO <= ReadData1
- `HI` out 32: HI register
- `LO` out 32: LO register
- `busy` out 1: operation in flight; CPU stalls on it
- `done` out 1: one-cycle pulse, HI/LO just updated by a mul/div

## Operation
- States: IDLE, CALC, FIX.
- **IDLE**
  - On `start`, latch `op`.
  - Latch operand magnitudes: absolute value for signed ops, raw value for unsigned.
  - Latch result signs: product/quotient negative iff operand signs differ (signed ops only); remainder sign follows the dividend.
  - Clear the 6-bit iteration counter, go to CALC.
- **CALC**
  - One iteration per cycle.
  - Multiply: 64-bit shift-add, LSB-first on multiplier.
  - Divide: restoring. Shift {rem,quot} left 1; if rem ≥ divisor, subtract and set quot LSB.
  - After the 32nd iteration (counter = 31), go to FIX.
- **FIX**
  - Apply two's-complement negation per the latched signs.
  - Write HI/LO. Multiply: HI = product[63:32], LO = product[31:0]. Divide: HI = remainder, LO = quotient.
  - Go to IDLE and assert `done` for the following cycle.
- **Divide by zero** (divisor = 0, div or divu): HI = ReadData1 as latched, LO = 32'hFFFF_FFFF, regardless of sign. Full latency still applies.
- **Signed overflow** (0x8000_0000 div 0xFFFF_FFFF): LO = 0x8000_0000, HI = 0.
- **HIwrite/LOwrite**
  - Honoured only in IDLE with `start` = 0; the register updates at the next edge.
  - Both may be asserted together.
  - Ignored while `busy`.
  - If asserted in the same cycle as `start`, they are dropped: `start` has priority.
- `start` while `busy` is ignored; no queuing.

## Timing
- Reset values: HI = 0, LO = 0, `busy` = 0, `done` = 0, state = IDLE, counter = 0.
- Reset is asynchronous and takes effect immediately, including mid-CALC or mid-FIX. The in-flight result is discarded and no `done` is produced.
- Let edge 0 be the edge sampling `start` = 1 in IDLE.
  - Edges 1..32: iterations.
  - Edge 33: FIX writes HI/LO.
- `busy` is registered: high from after edge 0 until after edge 33, i.e. 33 cycles.
- `done` is high for exactly the cycle after edge 33. `busy` is 0 in that same cycle.
- HI/LO hold their old values throughout the operation and change only at edge 33.
- A new `start` may be sampled in the `done` cycle: back-to-back issue.
- `mfhi` in the `done` cycle reads the new value.
- All outputs are driven directly from registers; there is no combinational input-to-output path.

## Test plan
1. **multu:** `op` = 01, 0xFFFF_FFFF × 0xFFFF_FFFF -> HI = 0xFFFF_FFFE, LO = 0x0000_0001. `busy` high 33 cycles; `done` in cycle 34 only.
2. **mult:** `op` = 00, 0xFFFF_FFFD (−3) × 5 -> HI = 0xFFFF_FFFF, LO = 0xFFFF_FFF1. Back-to-back start in the `done` cycle with 0x7FFF_FFFF × 2 -> HI = 0, LO = 0xFFFF_FFFE.
3. **div/divu signs:** div −7 ÷ 2 -> LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF. divu 7 ÷ 2 -> LO = 3, HI = 1. div 7 ÷ −2 -> LO = 0xFFFF_FFFD, HI = 1.
4. **Corner cases:**
   - div 0x1234_5678 ÷ 0 -> HI = 0x1234_5678, LO = 0xFFFF_FFFF.
   - div 0x8000_0000 ÷ 0xFFFF_FFFF -> LO = 0x8000_0000, HI = 0.
   - Both take full 33-cycle latency.
5. **Control interactions:**
   - `start` and `HIwrite` pulsed mid-CALC -> ignored; the result is unchanged.
   - In IDLE, `LOwrite` with ReadData1 = 0xCAFE_F00D -> LO = 0xCAFE_F00D next edge, `done` stays 0.
   - `start` + `HIwrite` in the same IDLE cycle -> HI ends as the mul/div result.
6. **Reset mid-operation:** assert `reset` asynchronously 10 cycles into a mult -> `busy`, `done`, HI and LO become 0 immediately. After release, a new divu 100 ÷ 7 -> LO = 14, HI = 2 with full latency.
